lcd_frame_writer: RTL and testbench

Frame writer for the ST7789V3 LCD path. After the controller finishes its init sequence, this block produces one full frame of 9-bit words into the driver's word FIFO: a CASET/RASET address window, RAMWR, then RGB565 pixels split into two bytes each. Pixels come from an internal colour-bar pattern generator. The block sits upstream of the FIFO → serdes chain and is enabled by the driver's WRMEM state.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_pattern_gen.sv | 65 ++++++
 rtl/lcd_frame_writer.sv | 168 ++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7789V3 frame writer: opcodes, RS encoding,
// FSM state type and the RGB565 colour-bar palette.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int HDR_WORDS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_PIX_HI = 3'd2,
    ST_PIX_LO = 3'd3,
    ST_DONE   = 3'd4
  } lcd_state_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Colour-bar source: raster x/y counters plus a bar index that steps every
// BAR_W columns. o_pixel/o_last describe the pixel the counters point at.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_advance,
  input  logic        i_clear,
  output logic [15:0] o_pixel,
  output logic        o_last
);

  localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int BAR_W = H_RES / 8;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [2:0]     r_bar;
  logic [BCW-1:0] r_bar_col;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == XW'(H_RES - 1));
  assign w_y_end = (r_y == YW'(V_RES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_bar     <= '0;
      r_bar_col <= '0;
    end else if (i_clear) begin
      r_x       <= '0;
      r_y       <= '0;
      r_bar     <= '0;
      r_bar_col <= '0;
    end else if (i_advance) begin
      if (w_x_end) begin
        r_x       <= '0;
        r_bar     <= '0;
        r_bar_col <= '0;
        r_y       <= w_y_end ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
        // Last bar never advances, so remainder columns keep its colour.
        if (r_bar_col == BCW'(BAR_W - 1) && r_bar != 3'd7) begin
          r_bar     <= r_bar + 1'b1;
          r_bar_col <= '0;
        end else begin
          r_bar_col <= r_bar_col + 1'b1;
        end
      end
    end
  end

  assign o_pixel = bar_colour(r_bar);
  assign o_last  = w_x_end && w_y_end;

endmodule

// File: rtl/lcd_frame_writer.sv
// Emits CASET/RASET/RAMWR header then one colour-bar frame as 9-bit words.
// Optional LCD_FRAME_LOOP_EN: frames repeat back-to-back after the first start.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 320,
  parameter int X_OFS = 0,
  parameter int Y_OFS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [8:0] wr_data,
  output lcd_state_e dbg_state
);

  localparam logic [15:0] XS = 16'(X_OFS);
  localparam logic [15:0] XE = 16'(X_OFS + H_RES - 1);
  localparam logic [15:0] YS = 16'(Y_OFS);
  localparam logic [15:0] YE = 16'(Y_OFS + V_RES - 1);

  function automatic logic [8:0] hdr_word(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_word = {RS_CMD,  CMD_CASET};
      4'd1:    hdr_word = {RS_DATA, XS[15:8]};
      4'd2:    hdr_word = {RS_DATA, XS[7:0]};
      4'd3:    hdr_word = {RS_DATA, XE[15:8]};
      4'd4:    hdr_word = {RS_DATA, XE[7:0]};
      4'd5:    hdr_word = {RS_CMD,  CMD_RASET};
      4'd6:    hdr_word = {RS_DATA, YS[15:8]};
      4'd7:    hdr_word = {RS_DATA, YS[7:0]};
      4'd8:    hdr_word = {RS_DATA, YE[15:8]};
      4'd9:    hdr_word = {RS_DATA, YE[7:0]};
      default: hdr_word = {RS_CMD,  CMD_RAMWR};
    endcase
  endfunction

  lcd_state_e  r_state, w_state;
  logic [3:0]  r_idx, w_idx;
  logic [8:0]  r_data, w_data;
  logic [7:0]  r_lo, w_lo;
  logic        r_last, w_last;
  logic        r_valid, w_valid;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        w_xfer;
  logic        w_gen_adv;
  logic        w_gen_clr;
  logic [15:0] w_pixel;
  logic        w_pixel_last;

  // Pixels are fetched from the generator one word ahead so wr_data can be
  // registered; the low byte and last-pixel flag ride along in r_lo/r_last.
  lcd_pattern_gen #(.H_RES(H_RES), .V_RES(V_RES)) u_gen (
    .clk      (clk),
    .rst      (rst),
    .i_advance(w_gen_adv),
    .i_clear  (w_gen_clr),
    .o_pixel  (w_pixel),
    .o_last   (w_pixel_last)
  );

  assign w_xfer = r_valid && wr_ready;

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_data    = r_data;
    w_lo      = r_lo;
    w_last    = r_last;
    w_valid   = r_valid;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_gen_adv = 1'b0;
    w_gen_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state   = ST_HDR;
          w_idx     = '0;
          w_data    = hdr_word(4'd0);
          w_valid   = 1'b1;
          w_busy    = 1'b1;
          w_gen_clr = 1'b1;
        end
      end
      ST_HDR: begin
        if (w_xfer) begin
          if (r_idx == 4'(HDR_WORDS - 1)) begin
            w_state   = ST_PIX_HI;
            w_data    = {RS_DATA, w_pixel[15:8]};
            w_lo      = w_pixel[7:0];
            w_last    = w_pixel_last;
            w_gen_adv = 1'b1;
          end else begin
            w_idx  = r_idx + 1'b1;
            w_data = hdr_word(r_idx + 1'b1);
          end
        end
      end
      ST_PIX_HI: begin
        if (w_xfer) begin
          w_state = ST_PIX_LO;
          w_data  = {RS_DATA, r_lo};
        end
      end
      ST_PIX_LO: begin
        if (w_xfer) begin
          if (r_last) begin
            w_done = 1'b1;
`ifdef LCD_FRAME_LOOP_EN
            w_state = ST_HDR;
            w_idx   = '0;
            w_data  = hdr_word(4'd0);
`else
            w_state = ST_DONE;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_data  = '0;
`endif
          end else begin
            w_state   = ST_PIX_HI;
            w_data    = {RS_DATA, w_pixel[15:8]};
            w_lo      = w_pixel[7:0];
            w_last    = w_pixel_last;
            w_gen_adv = 1'b1;
          end
        end
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_lo    <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_data  <= w_data;
      r_lo    <= w_lo;
      r_last  <= w_last;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_valid  = r_valid;
  assign wr_data   = r_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer at 16x4 (139 words per frame).
module tb_lcd_frame_writer;

  localparam int FRAME_WORDS = 139;

  localparam logic [8:0] HDR_TBL [11] = '{
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h10F,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h103, 9'h02C
  };
  localparam logic [15:0] BAR_TBL [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       wr_valid;
  logic       wr_ready;
  logic [8:0] wr_data;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int nw;
  int nc;

  logic [8:0] exp_q[$];
  logic [8:0] got_w [FRAME_WORDS];

  lcd_frame_writer #(.H_RES(16), .V_RES(4), .X_OFS(0), .Y_OFS(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_word(input int k);
    int p;
    logic [15:0] c;
    if (k < 11) return HDR_TBL[k];
    p = (k - 11) / 2;
    c = BAR_TBL[(p % 16) / 2];
    return ((k - 11) % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]};
  endfunction

  task automatic load_frame();
    exp_q.delete();
    for (int k = 0; k < FRAME_WORDS; k++) exp_q.push_back(exp_word(k));
  endtask

  // Drives wr_ready at pct% and scoreboards every presented word.
  task automatic run_frame(input int pct, input int poke_at, input int abort_at,
                           output int nwords, output int ncyc);
    logic [8:0] prev_d;
    bit prev_stall;
    prev_d = '0;
    prev_stall = 1'b0;
    nwords = 0;
    ncyc = 0;
    while (exp_q.size() != 0 && ncyc < 20000) begin
      if (abort_at >= 0 && nwords == abort_at) begin
        start = 1'b0;
        return;
      end
      if (prev_stall) begin
        check("stall_valid", wr_valid, 1);
        check("stall_data", wr_data, prev_d);
      end
      start = (nwords == poke_at);
      wr_ready = ($urandom_range(99) < pct);
      if (wr_valid) begin
        check("word", wr_data, exp_q[0]);
        if (nwords < FRAME_WORDS) got_w[nwords] = wr_data;
        if (wr_ready) begin
          void'(exp_q.pop_front());
          nwords++;
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_d = wr_data;
      step();
      ncyc++;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    check("frame_timeout", exp_q.size(), 0);
  endtask

  task automatic end_check();
    check("done_pulse", done, 1);
`ifdef LCD_FRAME_LOOP_EN
    check("loop_busy", busy, 1);
    check("loop_valid", wr_valid, 1);
    check("loop_restart", wr_data, 9'h02A);
`else
    check("end_valid", wr_valid, 0);
    check("end_busy", busy, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic post_frame();
    step();
    check("done_single", done, 0);
`ifdef LCD_FRAME_LOOP_EN
    do_reset();
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_valid", wr_valid, 1);
    check("start_word", wr_data, 9'h02A);
    check("start_busy", busy, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    wr_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", wr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", wr_data, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    step();
    check("idle_valid", wr_valid, 0);

    // Full-rate frame with header and pixel spot checks
    pulse_start();
    load_frame();
    run_frame(100, -1, -1, nw, nc);
    check("fr1_words", nw, FRAME_WORDS);
    check("fr1_cycles", nc, FRAME_WORDS);
    for (int k = 0; k < 11; k++) check("hdr", got_w[k], HDR_TBL[k]);
    check("pix0_hi", got_w[11], 9'h1FF);
    check("pix0_lo", got_w[12], 9'h1FF);
    check("pix2_hi", got_w[15], 9'h1FF);
    check("pix2_lo", got_w[16], 9'h1E0);
    check("pix15_hi", got_w[41], 9'h100);
    check("pix15_lo", got_w[42], 9'h100);
    check("pix16_hi", got_w[43], 9'h1FF);
    check("pix16_lo", got_w[44], 9'h1FF);
    end_check();
`ifdef LCD_FRAME_LOOP_EN
    load_frame();
    run_frame(100, -1, -1, nw, nc);
    check("loop2_cycles", nc, FRAME_WORDS);
    end_check();
    post_frame();
    pulse_start();
`else
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_ign_done", done, 0);
    check("done_start_ign_valid", wr_valid, 0);
    check("done_start_ign_busy", busy, 0);
    pulse_start();
`endif

    // Random back-pressure
    load_frame();
    run_frame(60, -1, -1, nw, nc);
    check("bp_words", nw, FRAME_WORDS);
    end_check();
    post_frame();

    // Start pulsed mid-frame is ignored
    pulse_start();
    load_frame();
    run_frame(100, 40, -1, nw, nc);
    check("mid_words", nw, FRAME_WORDS);
    check("mid_cycles", nc, FRAME_WORDS);
    end_check();
    post_frame();
`ifndef LCD_FRAME_LOOP_EN
    repeat (3) step();
    check("mid_no_restart", wr_valid, 0);
`endif

    // Reset mid-frame, then a fresh frame from header word 0
    pulse_start();
    load_frame();
    run_frame(70, -1, 50, nw, nc);
    check("abort_words", nw, 50);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("arst_valid", wr_valid, 0);
    check("arst_busy", busy, 0);
    step();
    rst = 1'b1;
    step();
    check("arst_idle", wr_valid, 0);
    pulse_start();
    load_frame();
    run_frame(100, -1, -1, nw, nc);
    check("rs_words", nw, FRAME_WORDS);
    end_check();
    post_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
